// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (output start, a, b, sub, input busy, done, sum, carry_out);
   modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
   modport master (output start, a, b, input busy, done, sum, carry_out);
   modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder (FA) built from two half adders plus an OR.
module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);
   logic s1, c1, c2;

   serial_adder_ha u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s1),  .c_o(c1));
   serial_adder_ha u_ha1 (.a_i(s1),  .b_i(cin_i), .s_o(s_o), .c_o(c2));

   assign cout_o = c1 | c2;
endmodule

module serial_adder_ha (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, through a single FA cell.
// Define SERIAL_ADDER_SUB_EN to add the sub input (A-B via inverted B, carry preset 1).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sa_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q;
   logic             fa_s, fa_co;
   logic             last_bit;
   logic [WIDTH-1:0] b_load;
   logic             cin_load;

   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_load   = bus.sub ? ~bus.b : bus.b;
      cin_load = bus.sub;
`else
      b_load   = bus.b;
      cin_load = 1'b0;
`endif
   end

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   serial_adder_fa u_fa (
      .a_i   (a_q[0]),
      .b_i   (b_q[0]),
      .cin_i (carry_q),
      .s_o   (fa_s),
      .cout_o(fa_co)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (last_bit)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state_q == ST_RUN);
      bus.done      = (state_q == ST_DONE);
      bus.sum       = sum_q;
      bus.carry_out = cout_q;
   end

   // Result register only changes on the final bit, so it holds across the next run.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.start) begin
               a_q     <= bus.a;
               b_q     <= b_load;
               cnt_q   <= '0;
               carry_q <= cin_load;
            end
            ST_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= fa_co;
               res_q   <= {fa_s, res_q[WIDTH-1:1]};
               if (last_bit) begin
                  sum_q  <= {fa_s, res_q[WIDTH-1:1]};
                  cout_q <= fa_co;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a plain-arithmetic reference model.
module tb_serial_adder;
   localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sub_v = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SERIAL_ADDER_SUB_EN
   assign bus.sub = sub_v;
`endif

   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] s, output logic c);
      int unsigned ai = a;
      int unsigned bi = b;
      if (sub) begin
         s = W'(ai - bi);
         c = (ai >= bi);
      end else begin
         s = W'(ai + bi);
         c = ((ai + bi) >> W) != 0;
      end
   endfunction

   // Drives one request and waits (bounded) for done; returns observations only.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat, output int nbusy, output logic [W-1:0] s, output logic c);
      lat = -1; nbusy = 0; s = 'x; c = 1'bx;
      @(negedge clk);
      bus.start = 1'b1; bus.a = a; bus.b = b; sub_v = sub;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); sub_v = 1'($urandom_range(0, 1));
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.busy) nbusy++;
         if (bus.done) begin
            lat = n; s = bus.sum; c = bus.carry_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.busy, bus.done, bus.sum, bus.carry_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                  bus.busy, bus.done, bus.sum, bus.carry_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, nb; logic [W-1:0] s; logic c;
      run_op(8'h0F, 8'h01, 1'b0, lat, nb, s, c);
      n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
      n_tests++; if (nb !== W) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, W); end
      n_tests++; if (s !== 8'h10 || c !== 1'b0) begin n_fail++; $display("FAIL basic_result: got %h/%b want 10/0", s, c); end
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", bus.done, bus.busy); end
   endtask

   task automatic test_hold();
      int got_done = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h01; sub_v = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
      repeat (2) @(negedge clk);
      n_tests++; if (bus.sum !== 8'h10 || bus.carry_out !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL hold_during_run: sum=%h cout=%b busy=%b want 10 0 1", bus.sum, bus.carry_out, bus.busy);
      end
      for (int n = 0; n < 20 && got_done == 0; n++) begin
         @(negedge clk);
         if (bus.done) got_done = 1;
      end
      n_tests++; if (got_done != 1 || bus.sum !== 8'h00 || bus.carry_out !== 1'b1) begin
         n_fail++; $display("FAIL overflow_result: done=%0d sum=%h cout=%b want 1 00 1", got_done, bus.sum, bus.carry_out);
      end
      repeat (5) @(negedge clk);
      n_tests++; if (bus.sum !== 8'h00 || bus.carry_out !== 1'b1) begin
         n_fail++; $display("FAIL hold_after_done: sum=%h cout=%b want 00 1", bus.sum, bus.carry_out);
      end
   endtask

   task automatic test_ignore_start();
      int pulses = 0; logic [W-1:0] s = 'x; logic c = 1'bx;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; sub_v = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (bus.done) begin pulses++; s = bus.sum; c = bus.carry_out; end
      end
      n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL ignore_start_pulses: got %0d want 1", pulses); end
      n_tests++; if (s !== 8'h10 || c !== 1'b0) begin n_fail++; $display("FAIL ignore_start_result: got %h/%b want 10/0", s, c); end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; sub_v = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1; bus.start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      n_tests++; if ({bus.busy, bus.done, bus.sum, bus.carry_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL reset_abort_state: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                            bus.busy, bus.done, bus.sum, bus.carry_out);
      end
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus.done || bus.busy) pulses++;
      end
      n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL reset_abort_activity: got %0d active cycles want 0", pulses); end
   endtask

   task automatic test_sub();
      int lat, nb; logic [W-1:0] s; logic c;
      run_op(8'h05, 8'h07, 1'b1, lat, nb, s, c);
      n_tests++; if (s !== 8'hFE || c !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %h/%b want fe/0", s, c); end
      run_op(8'h07, 8'h05, 1'b1, lat, nb, s, c);
      n_tests++; if (s !== 8'h02 || c !== 1'b1) begin n_fail++; $display("FAIL sub_no_borrow: got %h/%b want 02/1", s, c); end
   endtask

   task automatic test_back_to_back();
      int lat, nb; logic [W-1:0] s; logic c;
      run_op(8'h11, 8'h22, 1'b0, lat, nb, s, c);
      n_tests++; if (s !== 8'h33 || c !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 33/0", s, c); end
      run_op(8'h80, 8'h80, 1'b0, lat, nb, s, c);
      n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, W + 1); end
      n_tests++; if (s !== 8'h00 || c !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 00/1", s, c); end
   endtask

   task automatic test_random();
      int lat, nb; logic [W-1:0] a, b, s, es; logic sub, c, ec;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom);
         sub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
         model(a, b, sub, es, ec);
         run_op(a, b, sub, lat, nb, s, c);
         n_tests++;
         if (s !== es || c !== ec || lat !== W + 1) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h sub=%b got %h/%b lat=%0d want %h/%b lat=%0d",
                     i, a, b, sub, s, c, lat, es, ec, W + 1);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      test_reset();
      test_basic();
      test_hold();
      test_ignore_start();
      test_reset_abort();
      if (SUB_EN) test_sub();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-007 SHALL have port sub  input  1  1 = A-B, 0 = A+B; sampled with start (present only with SERIAL_ADDER_SUB_EN).
REQ-008 SHALL have port busy  output  1  high in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port sum  output  WIDTH  result.
REQ-011 SHALL have port carry_out  output  1  final carry; in subtract mode, 1 = no borrow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL load a and b into shift registers, clear the bit counter, preset the carry register, and enter RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through one full-adder cell: sum bit shifted into result MSB, cell carry registered.
REQ-015 Bit counter SHALL run 0..WIDTH-1; RUN->DONE on the edge processing bit WIDTH-1; no wrap beyond.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH.
REQ-018 sum and carry_out SHALL update only at the RUN->DONE edge and hold stable until the next accepted start completes.
REQ-019 start in RUN or DONE SHALL be ignored; no queuing.
REQ-020 Back-to-back: start in the cycle after done (IDLE) SHALL be accepted normally.
REQ-021 Operand changes after acceptance SHALL not affect the result.
REQ-022 Result SHALL be (A+B) mod 2^WIDTH, and carry_out SHALL be bit WIDTH of the true sum.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, carry_out=0, counter=0, carry register=0.
REQ-024 rst SHALL take priority over start and abort any RUN in progress without producing done.

Configuration
REQ-025 With SERIAL_ADDER_SUB_EN defined: port sub present; sub=1 SHALL preset carry to 1 and invert B bits, so result = (A-B) mod 2^WIDTH.
REQ-026 Without SERIAL_ADDER_SUB_EN: port sub absent, carry preset 0, add-only; all other behaviour identical.

Structure
REQ-027 Shared package serial_adder_pkg SHALL hold the FSM state enum typedef and the default-width constant.
REQ-028 The one-bit cell SHALL be a sub-module FA (a, b, cin -> sum, cout), built from two HA instances plus an OR.

Verification
REQ-029 WIDTH=8: a=0x0F, b=0x01, start at edge 0 -> busy for 8 cycles, done in cycle after edge 8, sum=0x10, carry_out=0.
REQ-030 a=0xFF, b=0x01 -> sum=0x00, carry_out=1; sum/carry_out hold after done until next result.
REQ-031 start pulsed again at cycle 3 of RUN with a=0x00, b=0x00 -> ignored; first result 0x10 unchanged, single done pulse.
REQ-032 rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0x00, carry_out=0; no done pulse follows.
REQ-033 SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0; a=0x07, b=0x05, sub=1 -> sum=0x02, carry_out=1.
REQ-034 Back-to-back start in the cycle after done, ops 0x80+0x80 -> sum=0x00, carry_out=1, done 9 cycles after second start.
